// File: rtl/alu_ctrl_pkg.sv
// Shared opcode and control-step encodings for the add/sub datapath sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_onehot_dec.sv
// Index-to-one-hot decoder with enable; output is all zero when disabled.
module onehot_dec #(
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic [RW-1:0]   idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    // Decode the selected register into a single enable bit.
    always_comb begin
        onehot = {NREG{1'b0}};
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = {NREG{1'b0}};
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the shared 8-bit datapath: one instruction per run/done
// transaction, walked through up to three control steps.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREG = 8,
    parameter int RW   = $clog2(NREG),
    parameter int IW   = 2 + 2 * RW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [IW-1:0]   instr,
    output logic            busy,
    output logic            done,
    output logic [NREG-1:0] rin,
    output logic [NREG-1:0] rout,
    output logic            dinout,
    output logic            ain,
    output logic            gin,
    output logic            gout,
    output logic            addsub
);

    state_t          state_r;
    state_t          next_state_s;
    logic [IW-1:0]   ir_r;
    logic [1:0]      op_s;
    logic [RW-1:0]   x_s;
    logic [RW-1:0]   y_s;
    logic            rin_en_s;
    logic            rout_en_s;
    logic [RW-1:0]   rout_idx_s;

    assign op_s = ir_r[IW-1 -: 2];
    assign x_s  = ir_r[IW-3 -: RW];
    assign y_s  = ir_r[RW-1:0];

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= T0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register loads only when an instruction is accepted from idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir_r <= {IW{1'b0}};
        end else if ((state_r == T0) && run) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Next-step selection; only add/sub continue past the first step.
    always_comb begin
        next_state_s = T0;
        case (state_r)
            T0:      next_state_s = run ? T1 : T0;
            T1:      next_state_s = op_s[1] ? T2 : T0;
            T2:      next_state_s = T3;
            T3:      next_state_s = T0;
            default: next_state_s = T0;
        endcase
    end

    // Strobe decode from step and IR only, so outputs never see run/instr.
    always_comb begin
        busy       = (state_r != T0);
        done       = 1'b0;
        dinout     = 1'b0;
        ain        = 1'b0;
        gin        = 1'b0;
        gout       = 1'b0;
        addsub     = 1'b0;
        rin_en_s   = 1'b0;
        rout_en_s  = 1'b0;
        rout_idx_s = x_s;
        case (state_r)
            T1: begin
                case (op_s)
                    OP_MV: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = y_s;
                        rin_en_s   = 1'b1;
                        done       = 1'b1;
                    end
                    OP_MVI: begin
                        dinout   = 1'b1;
                        rin_en_s = 1'b1;
                        done     = 1'b1;
                    end
                    default: begin
                        rout_en_s  = 1'b1;
                        rout_idx_s = x_s;
                        ain        = 1'b1;
                    end
                endcase
            end
            T2: begin
                rout_en_s  = 1'b1;
                rout_idx_s = y_s;
                gin        = 1'b1;
                addsub     = op_s[0];
            end
            T3: begin
                gout     = 1'b1;
                rin_en_s = 1'b1;
                done     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    onehot_dec #(.NREG(NREG), .RW(RW)) u_rin_dec (
        .idx    (x_s),
        .en     (rin_en_s),
        .onehot (rin)
    );

    onehot_dec #(.NREG(NREG), .RW(RW)) u_rout_dec (
        .idx    (rout_idx_s),
        .en     (rout_en_s),
        .onehot (rout)
    );

endmodule
